// File: rtl/cnn_dma_pkg.sv
// Shared definitions for the CNN DMA responder: mode encodings, FSM states
// and default geometry.
package cnn_dma_pkg;

  localparam int WIN_DEF = 5;
  localparam int AW_DEF  = 16;
  localparam int DW_DEF  = 16;

  localparam logic [1:0] MODE_WIN  = 2'd0;
  localparam logic [1:0] MODE_WR   = 2'd1;
  localparam logic [1:0] MODE_FILT = 2'd2;
  localparam logic [1:0] MODE_BIAS = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RD_WIN,
    WR_ONE,
    RD_FILT,
    RD_BIAS,
    DONE
  } state_e;

endpackage

// File: rtl/dma_addr_gen.sv
// Address sequencer: walks a WIN x WIN window (row base += offset, column += 1)
// or a linear run of filter/bias words, and flags group and operation ends.
module dma_addr_gen
  import cnn_dma_pkg::*;
#(
  parameter int WIN = WIN_DEF,
  parameter int AW  = AW_DEF,
  localparam int SW = $clog2(WIN * WIN),
  localparam int CW = $clog2(WIN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          step,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] start_address,
  input  logic [AW-1:0] offset,
  input  logic [15:0]   count,
  output logic [AW-1:0] addr,
  output logic [SW-1:0] slot,
  output logic [15:0]   grp,
  output logic          end_grp,
  output logic          last,
  output logic          empty
);

  logic [AW-1:0] addr_q, addr_d, row_base_q, row_base_d, offset_q, offset_d;
  logic [CW-1:0] col_q, col_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [15:0]   grp_q, grp_d, count_q, count_d;
  logic [1:0]    mode_q, mode_d;
  logic          col_last, slot_last, grp_last;

  assign col_last  = (col_q == CW'(WIN - 1));
  assign slot_last = (slot_q == SW'(WIN * WIN - 1));
  assign grp_last  = (grp_q == count_q - 16'd1);

  // Next-position logic: load on init, advance one word per issued access.
  always_comb begin
    addr_d     = addr_q;
    row_base_d = row_base_q;
    offset_d   = offset_q;
    col_d      = col_q;
    slot_d     = slot_q;
    grp_d      = grp_q;
    count_d    = count_q;
    mode_d     = mode_q;
    if (init) begin
      addr_d     = start_address;
      row_base_d = start_address;
      offset_d   = offset;
      count_d    = count;
      mode_d     = mode;
      col_d      = '0;
      slot_d     = '0;
      grp_d      = '0;
    end else if (step) begin
      // Only window reads jump by the row stride; everything else is linear.
      if (mode_q == MODE_WIN && col_last) begin
        row_base_d = row_base_q + offset_q;
        addr_d     = row_base_q + offset_q;
      end else begin
        addr_d = addr_q + AW'(1);
      end
      col_d  = col_last ? '0 : col_q + CW'(1);
      slot_d = slot_last ? '0 : slot_q + SW'(1);
      if (mode_q == MODE_BIAS || slot_last) grp_d = grp_q + 16'd1;
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      row_base_q <= '0;
      offset_q   <= '0;
      col_q      <= '0;
      slot_q     <= '0;
      grp_q      <= '0;
      count_q    <= '0;
      mode_q     <= MODE_WIN;
    end else begin
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      offset_q   <= offset_d;
      col_q      <= col_d;
      slot_q     <= slot_d;
      grp_q      <= grp_d;
      count_q    <= count_d;
      mode_q     <= mode_d;
    end
  end

  assign addr    = addr_q;
  assign slot    = slot_q;
  assign grp     = grp_q;
  assign empty   = (count_q == 16'd0);
  assign end_grp = (mode_q == MODE_BIAS) || slot_last;
  assign last    = (mode_q == MODE_BIAS) ? grp_last :
                   (mode_q == MODE_FILT) ? (slot_last && grp_last) : slot_last;

endmodule

// File: rtl/window_dma_responder.sv
// DMA responder for a CNN controller: window reads, single writes and
// filter/bias loads. Reads are issued back to back; each read's tag rides a
// two-stage pipeline so the returning word lands in the right slot.
// win_data / fb_filter are flat: word (r*WIN+c) sits at bits [(r*WIN+c)*DW +: DW].
module window_dma_responder
  import cnn_dma_pkg::*;
#(
  parameter int WIN = WIN_DEF,
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  finish,
  input  logic [AW-1:0]         start_address,
  input  logic [AW-1:0]         offset,
  input  logic [1:0]            mode,
  input  logic [15:0]           filter_number,
  input  logic [DW-1:0]         wr_data,
  output logic [WIN*WIN*DW-1:0] win_data,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rdata,
  output logic                  fb_write,
  output logic                  fb_bias_or_filter,
  output logic [15:0]           fb_index,
  output logic [WIN*WIN*DW-1:0] fb_filter,
  output logic [DW-1:0]         fb_bias
);

  localparam int SW = $clog2(WIN * WIN);

  typedef struct packed {
    logic          valid;
    logic [SW-1:0] slot;
    logic [15:0]   grp;
    logic          end_grp;
    logic          last;
  } tag_t;

  state_e                        state_q, state_d;
  logic                          finish_q, finish_d, issuing_q, issuing_d;
  logic [DW-1:0]                 wr_data_q, wr_data_d;
  logic                          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0]                 mem_addr_q, mem_addr_d;
  logic [DW-1:0]                 mem_wdata_q, mem_wdata_d;
  logic                          fb_write_q, fb_write_d, fb_bof_q, fb_bof_d;
  logic [15:0]                   fb_index_q, fb_index_d;
  logic [DW-1:0]                 fb_bias_q, fb_bias_d;
  logic [WIN*WIN-1:0][DW-1:0]    win_q, win_d, filt_q, filt_d;
  tag_t                          p1_q, p1_d, p2_q, p2_d;

  logic                          gen_init, gen_step, gen_end, gen_last, gen_empty;
  logic [AW-1:0]                 gen_addr;
  logic [SW-1:0]                 gen_slot;
  logic [15:0]                   gen_grp;

  dma_addr_gen #(.WIN(WIN), .AW(AW)) u_addr_gen (
    .clk          (clk),
    .rst_n        (reset),
    .init         (gen_init),
    .step         (gen_step),
    .mode         (mode),
    .start_address(start_address),
    .offset       (offset),
    .count        (filter_number),
    .addr         (gen_addr),
    .slot         (gen_slot),
    .grp          (gen_grp),
    .end_grp      (gen_end),
    .last         (gen_last),
    .empty        (gen_empty)
  );

  // FSM next state, access issue and read-data capture.
  always_comb begin
    state_d     = state_q;
    finish_d    = finish_q;
    issuing_d   = issuing_q;
    wr_data_d   = wr_data_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fb_write_d  = 1'b0;
    fb_bof_d    = fb_bof_q;
    fb_index_d  = fb_index_q;
    fb_bias_d   = fb_bias_q;
    win_d       = win_q;
    filt_d      = filt_q;
    p1_d        = '0;
    p2_d        = p1_q;
    gen_init    = 1'b0;
    gen_step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          gen_init  = 1'b1;
          wr_data_d = wr_data;
          issuing_d = 1'b1;
          case (mode)
            MODE_WIN:  state_d = RD_WIN;
            MODE_WR:   state_d = WR_ONE;
            MODE_FILT: state_d = RD_FILT;
            default:   state_d = RD_BIAS;
          endcase
        end
      end
      WR_ONE: begin
        if (issuing_q) begin
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = gen_addr;
          mem_wdata_d = wr_data_q;
          issuing_d   = 1'b0;
        end else begin
          state_d  = DONE;
          finish_d = 1'b1;
        end
      end
      RD_WIN, RD_FILT, RD_BIAS: begin
        if (issuing_q) begin
          // A zero-length filter/bias load completes without touching memory.
          if (state_q != RD_WIN && gen_empty) begin
            state_d   = DONE;
            finish_d  = 1'b1;
            issuing_d = 1'b0;
          end else begin
            mem_en_d   = 1'b1;
            mem_addr_d = gen_addr;
            gen_step   = 1'b1;
            p1_d       = '{valid: 1'b1, slot: gen_slot, grp: gen_grp,
                           end_grp: gen_end, last: gen_last};
            if (gen_last) issuing_d = 1'b0;
          end
        end
        if (p2_q.valid) begin
          if (state_q == RD_WIN) begin
            win_d[p2_q.slot] = mem_rdata;
          end else if (state_q == RD_FILT) begin
            filt_d[p2_q.slot] = mem_rdata;
            if (p2_q.end_grp) begin
              fb_write_d = 1'b1;
              fb_bof_d   = 1'b0;
              fb_index_d = p2_q.grp;
            end
          end else begin
            fb_bias_d  = mem_rdata;
            fb_write_d = 1'b1;
            fb_bof_d   = 1'b1;
            fb_index_d = p2_q.grp;
          end
          if (p2_q.last) begin
            state_d  = DONE;
            finish_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (!start) begin
          state_d  = IDLE;
          finish_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      finish_q    <= 1'b0;
      issuing_q   <= 1'b0;
      wr_data_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fb_write_q  <= 1'b0;
      fb_bof_q    <= 1'b0;
      fb_index_q  <= '0;
      fb_bias_q   <= '0;
      win_q       <= '0;
      filt_q      <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
    end else begin
      state_q     <= state_d;
      finish_q    <= finish_d;
      issuing_q   <= issuing_d;
      wr_data_q   <= wr_data_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      fb_write_q  <= fb_write_d;
      fb_bof_q    <= fb_bof_d;
      fb_index_q  <= fb_index_d;
      fb_bias_q   <= fb_bias_d;
      win_q       <= win_d;
      filt_q      <= filt_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
    end
  end

  assign finish            = finish_q;
  assign mem_en            = mem_en_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign fb_write          = fb_write_q;
  assign fb_bias_or_filter = fb_bof_q;
  assign fb_index          = fb_index_q;
  assign fb_bias           = fb_bias_q;
  assign win_data          = win_q;
  assign fb_filter         = filt_q;

endmodule

// File: tb/tb_window_dma_responder.sv
// Directed bench for window_dma_responder: a vector table of operations with
// hand-computed timing and counts, plus start-drop and mid-operation reset.
module tb_window_dma_responder;

  localparam int WIN = 5;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int NW  = WIN * WIN;

  logic              clk, rst_n, start, finish;
  logic [AW-1:0]     start_address, offset;
  logic [1:0]        mode;
  logic [15:0]       filter_number;
  logic [DW-1:0]     wr_data, mem_rdata;
  logic [NW*DW-1:0]  win_data, fb_filter;
  logic              mem_en, mem_we, fb_write, fb_bias_or_filter;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata, fb_bias;
  logic [15:0]       fb_index;
  logic [DW-1:0]     pat;

  window_dma_responder #(.WIN(WIN), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(rst_n), .start(start), .finish(finish),
    .start_address(start_address), .offset(offset), .mode(mode),
    .filter_number(filter_number), .wr_data(wr_data), .win_data(win_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fb_write(fb_write), .fb_bias_or_filter(fb_bias_or_filter),
    .fb_index(fb_index), .fb_filter(fb_filter), .fb_bias(fb_bias)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: content of address a is a ^ pat, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_addr ^ pat;
  end

  typedef struct {
    logic [15:0]      idx;
    logic             bof;
    logic [DW-1:0]    bias;
    logic [NW*DW-1:0] filt;
  } fb_ev_t;

  logic [AW-1:0] rd_addrs[$];
  fb_ev_t        fb_evs[$];
  int            wr_cnt = 0;
  logic [AW-1:0] wr_addr_seen;
  logic [DW-1:0] wr_data_seen;

  // Bus monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        wr_cnt++;
        wr_addr_seen = mem_addr;
        wr_data_seen = mem_wdata;
      end else begin
        rd_addrs.push_back(mem_addr);
      end
    end
    if (fb_write) fb_evs.push_back('{fb_index, fb_bias_or_filter, fb_bias, fb_filter});
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ":finish"}, 32'(finish), 0);
    check({tag, ":mem_en"}, 32'(mem_en), 0);
    check({tag, ":mem_we"}, 32'(mem_we), 0);
    check({tag, ":mem_addr"}, 32'(mem_addr), 0);
    check({tag, ":mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, ":fb_write"}, 32'(fb_write), 0);
    check({tag, ":fb_bof"}, 32'(fb_bias_or_filter), 0);
    check({tag, ":fb_index"}, 32'(fb_index), 0);
    check({tag, ":fb_bias"}, 32'(fb_bias), 0);
    check({tag, ":win_data_nonzero"}, 32'(|win_data), 0);
    check({tag, ":fb_filter_nonzero"}, 32'(|fb_filter), 0);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] sa;
    logic [15:0] off;
    logic [15:0] fn;
    logic [15:0] wd;
    logic [15:0] pat;
    int          fin;
    int          nrd;
    int          nwr;
    int          nfb;
  } vec_t;

  function automatic logic [AW-1:0] exp_addr(input vec_t v, input int k);
    logic [AW-1:0] a;
    if (v.mode == 2'd0) a = v.sa + 16'(k / WIN) * v.off + 16'(k % WIN);
    else a = v.sa + 16'(k);
    return a;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int rd0 = rd_addrs.size();
    int fb0 = fb_evs.size();
    int wr0 = wr_cnt;
    int fe  = -1;
    logic [AW-1:0] ea;
    @(negedge clk);
    pat = v.pat; mode = v.mode; start_address = v.sa; offset = v.off;
    filter_number = v.fn; wr_data = v.wd; start = 1'b1;
    @(posedge clk);  // edge 0: start sampled
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (n == 2) begin  // scramble inputs while busy; they must be ignored
        start_address = ~v.sa; offset = 16'd7; mode = v.mode ^ 2'd1;
        filter_number = v.fn + 16'd3; wr_data = 16'h0;
      end
      if (finish) begin fe = n; break; end
    end
    check($sformatf("v%0d finish_edge", id), fe, v.fin);
    check($sformatf("v%0d mem_en_in_done", id), 32'(mem_en), 0);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    check($sformatf("v%0d finish_drop", id), 32'(finish), 0);
    check($sformatf("v%0d reads", id), rd_addrs.size() - rd0, v.nrd);
    check($sformatf("v%0d writes", id), wr_cnt - wr0, v.nwr);
    check($sformatf("v%0d fb_writes", id), fb_evs.size() - fb0, v.nfb);
    if (v.nwr > 0 && wr_cnt > wr0) begin
      check($sformatf("v%0d wr_addr", id), 32'(wr_addr_seen), 32'(v.sa));
      check($sformatf("v%0d wr_data", id), 32'(wr_data_seen), 32'(v.wd));
    end
    for (int k = 0; k < v.nrd && rd0 + k < rd_addrs.size(); k++)
      check($sformatf("v%0d rd_addr[%0d]", id, k), 32'(rd_addrs[rd0 + k]), 32'(exp_addr(v, k)));
    if (v.mode == 2'd0)
      for (int k = 0; k < NW; k++) begin
        ea = exp_addr(v, k);
        check($sformatf("v%0d win[%0d]", id, k), 32'(win_data[k*DW +: DW]), 32'(ea ^ v.pat));
      end
    for (int f = 0; f < v.nfb && fb0 + f < fb_evs.size(); f++) begin
      fb_ev_t e = fb_evs[fb0 + f];
      check($sformatf("v%0d fb_index[%0d]", id, f), 32'(e.idx), f);
      check($sformatf("v%0d fb_bof[%0d]", id, f), 32'(e.bof), 32'(v.mode == 2'd3));
      if (v.mode == 2'd3) begin
        ea = v.sa + 16'(f);
        check($sformatf("v%0d fb_bias[%0d]", id, f), 32'(e.bias), 32'(ea ^ v.pat));
      end else begin
        for (int s = 0; s < NW; s++) begin
          ea = v.sa + 16'(f * NW + s);
          check($sformatf("v%0d fb_filt[%0d][%0d]", id, f, s), 32'(e.filt[s*DW +: DW]), 32'(ea ^ v.pat));
        end
      end
    end
    $display("txn %0d: mode=%0d sa=%h fn=%0d finish_edge=%0d reads=%0d fb=%0d",
             id, v.mode, v.sa, v.fn, fe, rd_addrs.size() - rd0, fb_evs.size() - fb0);
  endtask

  vec_t vecs[9];

  initial begin
    int base, wbase, fe;
    vecs[0] = '{2'd0, 16'd100,   16'd32,  16'd0, 16'h0000, 16'h0000, 27, 25, 0, 0};
    vecs[1] = '{2'd1, 16'h1234,  16'd0,   16'd0, 16'hBEEF, 16'h0000, 2,  0,  1, 0};
    vecs[2] = '{2'd2, 16'd150,   16'd0,   16'd2, 16'h0000, 16'h00FF, 52, 50, 0, 2};
    vecs[3] = '{2'd3, 16'd50550, 16'd0,   16'd6, 16'h0000, 16'h0F0F, 8,  6,  0, 6};
    vecs[4] = '{2'd2, 16'd300,   16'd0,   16'd0, 16'h0000, 16'h0000, 1,  0,  0, 0};
    vecs[5] = '{2'd3, 16'd300,   16'd0,   16'd0, 16'h0000, 16'h0000, 1,  0,  0, 0};
    vecs[6] = '{2'd0, 16'hFFF0,  16'd5,   16'd0, 16'h0000, 16'h1111, 27, 25, 0, 0};
    vecs[7] = '{2'd3, 16'hFFFF,  16'd0,   16'd1, 16'h0000, 16'hA5A5, 3,  1,  0, 1};
    vecs[8] = '{2'd2, 16'hFFF0,  16'd0,   16'd1, 16'h0000, 16'h3C3C, 27, 25, 0, 1};

    rst_n = 1'b1; start = 1'b0; start_address = '0; offset = '0; mode = '0;
    filter_number = '0; wr_data = '0; pat = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset_state");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Start dropped right after being sampled: the window read still completes.
    @(negedge clk);
    pat = 16'h0; mode = 2'd0; start_address = 16'h0200; offset = 16'h0100; start = 1'b1;
    base = rd_addrs.size();
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    fe = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (finish) begin fe = n; break; end
    end
    check("drop finish_edge", fe, 27);
    @(posedge clk); #1;
    check("drop finish_clear", 32'(finish), 0);
    check("drop reads", rd_addrs.size() - base, 25);
    check("drop win[24]", 32'(win_data[24*DW +: DW]), 32'(16'h0200 + 16'h0400 + 16'd4));
    $display("txn drop: finish_edge=%0d reads=%0d", fe, rd_addrs.size() - base);

    // Reset pulse mid window read: outputs clear immediately, no access after.
    @(negedge clk);
    pat = 16'h0; mode = 2'd0; start_address = 16'hFFF0; offset = 16'd5; start = 1'b1;
    base = rd_addrs.size();
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    check("mid_reset reads_before", rd_addrs.size() - base, 9);
    if (rd_addrs.size() - base >= 9) begin
      check("mid_reset rd_addr[5]", 32'(rd_addrs[base + 5]), 32'h0000FFF5);
      check("mid_reset rd_addr[8]", 32'(rd_addrs[base + 8]), 32'h0000FFF8);
    end
    @(negedge clk) start = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    base = rd_addrs.size();
    wbase = wr_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("post_reset reads", rd_addrs.size() - base, 0);
    check("post_reset writes", wr_cnt - wbase, 0);
    check("post_reset finish", 32'(finish), 0);
    $display("txn reset: reads_after=%0d", rd_addrs.size() - base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_dma_responder.md
WINDOW_DMA_RESPONDER -- requirements
Module: window_dma_responder

Interface
REQ-001 SHALL have parameter WIN, 5, window/filter edge length.
REQ-002 SHALL have parameter AW, 16, memory address width.
REQ-003 SHALL have parameter DW, 16, data word width.
REQ-004 SHALL have one clock and asynchronous active-low reset, ports named as in the codebase: clk  in  1  clock (rising edge); reset  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports start in 1 (request level from CNN controller) and finish out 1 (request complete).
REQ-006 SHALL have ports start_address in AW, offset in AW (row stride, words), mode in 2 (0 window read, 1 single write, 2 filter load, 3 bias load) and filter_number in 16 (filter or bias count).
REQ-007 SHALL have ports wr_data in DW (word to write, mode 1) and win_data out WINxWINxDW (assembled window, mode 0).
REQ-008 SHALL have memory ports mem_en out 1, mem_we out 1, mem_addr out AW, mem_wdata out DW, mem_rdata in DW (valid one cycle after mem_en=1, mem_we=0).
REQ-009 SHALL have filter-buffer ports fb_write out 1, fb_bias_or_filter out 1 (1 = bias), fb_index out 16, fb_filter out WINxWINxDW, fb_bias out DW.

Function
REQ-010 SHALL sample start only in IDLE; start=1 in IDLE latches start_address, offset, mode, filter_number and wr_data, then enters the state selected by mode.
REQ-011 SHALL ignore input changes and start deassertion while busy; an operation always completes.
REQ-012 SHALL use states IDLE, RD_WIN, WR_ONE, RD_FILT, RD_BIAS, DONE; DONE holds finish=1 until start=0, then returns to IDLE with finish=0 on the next edge.
REQ-013 SHALL issue at most one memory access per cycle, back to back, capturing mem_rdata the cycle after issue.
REQ-014 RD_WIN SHALL read address start_address + r*offset + c for r, c in 0..WIN-1, row-major, into win_data[r][c]; finish rises exactly WIN*WIN+2 edges after start is sampled (27 for WIN=5).
REQ-015 WR_ONE SHALL assert mem_en=1, mem_we=1, mem_addr=start_address, mem_wdata=wr_data for exactly one cycle; finish rises 2 edges after start is sampled.
REQ-016 RD_FILT SHALL, for f in 0..filter_number-1, read WIN*WIN consecutive words from start_address + f*WIN*WIN into fb_filter, then pulse fb_write for one cycle with fb_index=f, fb_bias_or_filter=0.
REQ-017 RD_BIAS SHALL read filter_number consecutive words from start_address, pulsing fb_write per word with fb_index=i, fb_bias=word, fb_bias_or_filter=1.
REQ-018 SHALL compute addresses incrementally (row base += offset, column += 1), with no multiplier; arithmetic SHALL wrap modulo 2^AW.
REQ-019 filter_number=0 in mode 2 or 3 SHALL produce no memory or fb_write activity and go directly to DONE on the next edge.
REQ-020 win_data and fb_filter SHALL hold their last assembled values until overwritten by a later operation.
REQ-021 mem_en, mem_we and fb_write SHALL be 0 in IDLE and DONE.

Reset
REQ-022 reset=0 SHALL asynchronously force state IDLE and set every output to 0 (finish, mem_*, fb_*, win_data, fb_filter, fb_bias, fb_index).
REQ-023 reset asserted mid-operation SHALL abort it; after release no access occurs until a new start is sampled.

Structure
REQ-024 A shared package cnn_dma_pkg SHALL hold the mode encodings (MODE_WIN=0, MODE_WR=1, MODE_FILT=2, MODE_BIAS=3), the state enum and the WIN/AW/DW defaults.
REQ-025 One sub-module, dma_addr_gen, SHALL generate the row/column/filter address sequence and last-word flags; the top level holds the FSM and capture registers.

Verification
REQ-026 Mode 0, start_address=100, offset=32, memory[a]=a: win_data[r][c]=100+32r+c; finish at edge 27; finish drops one edge after start=0.
REQ-027 Mode 1, start_address=0x1234, wr_data=0xBEEF: one write cycle with mem_we=1 to 0x1234; finish at edge 2; no other memory access.
REQ-028 Mode 2, start_address=150, filter_number=2: 50 reads 150..199; two fb_write pulses with fb_index 0 then 1 and correct 25-word fb_filter contents.
REQ-029 Mode 3, filter_number=6, start_address=50550: six fb_write pulses with fb_bias_or_filter=1, fb_index 0..5, fb_bias=memory[50550+i].
REQ-030 Mode 0 at start_address=0xFFF0, offset=5: addresses wrap past 0xFFFF; a reset pulse at edge 10 zeroes all outputs immediately with no further mem_en.
REQ-031 filter_number=0 in mode 2: finish at edge 1, zero mem_en and fb_write pulses.
